can_rx_frame_seq: RTL and testbench
===================================

CAN_RX_FRAME_SEQ -- requirements
Module: can_rx_frame_seq

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have port reset_mode  input  1  synchronous soft reset, same effect as rst at next edge.
REQ-004 SHALL have port bit_start_point  input  1  one-cycle pulse marking the sample point of a bus bit.
REQ-005 SHALL have port rx_bit  input  1  sampled bus level (0 dominant, 1 recessive), valid while bit_start_point=1.
REQ-006 SHALL have port remove_stuff_bit  input  1  de-stuffer flag: current bit is a stuff bit.
REQ-007 SHALL have port bit_de_stuffing_en  output  1  enables the de-stuffer.
REQ-008 SHALL have port rx_bit_valid  output  1  one-cycle pulse: rx_bit_data is a destuffed frame bit.
REQ-009 SHALL have port rx_bit_data  output  1  destuffed bit value.
REQ-010 SHALL have port field  output  3  current state encoding (see REQ-014).
REQ-011 SHALL have port rx_dlc  output  4  DLC captured from the current frame.
REQ-012 SHALL have port frame_done  output  1  one-cycle pulse: error-free end of EOF.
REQ-013 SHALL have port err  output  2  one-cycle error pulse: 01 stuff, 10 form, 11 unsupported (extended) format; 00 none.

Function
REQ-014 SHALL implement states WAIT_IDLE=0, IDLE=1, ARB=2, CTRL=3, DATA=4, CRC=5, TAIL=6, EOF=7, driven on field.
REQ-015 SHALL evaluate state, counters and checks only in cycles with bit_start_point=1; all outputs registered (visible the cycle after the sample).
REQ-016 SHALL use a 7-bit bit counter bit_cnt, cleared on every state entry, incremented per non-stuff bit consumed.
REQ-017 WAIT_IDLE: count consecutive recessive bits; dominant restarts count; 11th recessive -> IDLE.
REQ-018 IDLE: dominant bit (SOF) -> ARB; recessive stays.
REQ-019 ARB: consume 12 bits (11 ID + RTR); capture RTR on 12th -> CTRL.
REQ-020 CTRL: consume 6 bits (IDE, r0, DLC[3:0] MSB first); IDE recessive -> err=11, WAIT_IDLE; otherwise capture rx_dlc on 6th.
REQ-021 After CTRL: data length = 0 if RTR recessive, else 8*min(rx_dlc,8) bits; length 0 -> CRC directly, else DATA; DATA consumes that many bits -> CRC.
REQ-022 CRC: consume 15 bits -> TAIL.
REQ-023 TAIL: 3 bits (CRC delimiter, ACK slot, ACK delimiter); delimiters dominant -> err=10, WAIT_IDLE; ACK slot value ignored -> EOF after 3rd.
REQ-024 EOF: 7 bits all recessive -> frame_done pulse on 7th, IDLE; any dominant -> err=10, WAIT_IDLE.
REQ-025 bit_de_stuffing_en SHALL be 1 in ARB, CTRL, DATA, CRC and on the IDLE->ARB transition sample; 0 elsewhere.
REQ-026 When remove_stuff_bit=1 at a sample in ARB..CRC: bit not counted, no rx_bit_valid; if rx_bit equals previous sampled bit -> err=01, WAIT_IDLE.
REQ-027 rx_bit_valid SHALL pulse with rx_bit_data=rx_bit for every non-stuff bit consumed in ARB, CTRL, DATA, CRC (SOF excluded).
REQ-028 remove_stuff_bit SHALL be ignored outside ARB..CRC.
REQ-029 Only one err code per cycle; priority stuff > unsupported > form.
REQ-030 reset_mode SHALL override all other conditions in the same cycle.

Reset
REQ-031 On rst or reset_mode: state WAIT_IDLE, bit_cnt=0, idle counter=0, rx_dlc=0, RTR=0, previous bit=1, all outputs 0 except field=0.
REQ-032 rst asserted mid-frame SHALL abort immediately without frame_done or err pulse.

Verification
REQ-033 After reset, 11 recessive bits then dominant -> field 0->1->2, bit_de_stuffing_en=1.
REQ-034 Base data frame DLC=2, RTR=0, valid stuffing -> 12+6+16+15=49 rx_bit_valid pulses, rx_dlc=2, one frame_done after EOF.
REQ-035 Remote frame DLC=15 -> CTRL goes straight to CRC, 33 valid pulses, frame_done.
REQ-036 Five dominant then stuff bit dominant with remove_stuff_bit=1 in DATA -> err=01, field=0, no frame_done.
REQ-037 Dominant at EOF bit 4 -> err=10, WAIT_IDLE; IDE recessive -> err=11.
REQ-038 rst pulse during DATA -> all outputs 0 next cycle, field=0, 11 recessive bits needed before next SOF.

Source files
------------

// File: rtl/can_rx_frame_seq.sv
// CAN receive frame sequencer: tracks a base-format frame per sampled bit, de-stuffs and flags errors.
// All outputs are registered one cycle after a bit sample; there is no backpressure because the bus sets the pace.
module can_rx_frame_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       reset_mode,
  input  logic       bit_start_point,
  input  logic       rx_bit,
  input  logic       remove_stuff_bit,
  output logic       bit_de_stuffing_en,
  output logic       rx_bit_valid,
  output logic       rx_bit_data,
  output logic [2:0] field,
  output logic [3:0] rx_dlc,
  output logic       frame_done,
  output logic [1:0] err
);

  typedef enum logic [2:0] {
    WAIT_IDLE = 3'd0,
    IDLE      = 3'd1,
    ARB       = 3'd2,
    CTRL      = 3'd3,
    DATA      = 3'd4,
    CRC       = 3'd5,
    TAIL      = 3'd6,
    EOF       = 3'd7
  } state_t;

  state_t     state;
  logic [6:0] bit_cnt;
  logic [6:0] data_len;
  logic [3:0] idle_cnt;
  logic       rtr;
  logic       prev_bit;
  logic [2:0] dlc_sh;
  logic [3:0] dlc_new;
  logic [6:0] len_new;
  logic       stuff_region;

  assign field = state;

  always_comb begin
    dlc_new      = {dlc_sh, rx_bit};
    len_new      = (dlc_new > 4'd8) ? 7'd64 : {dlc_new, 3'b000};
    stuff_region = (state == ARB) || (state == CTRL) || (state == DATA) || (state == CRC);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state              <= WAIT_IDLE;
      bit_cnt            <= 7'd0;
      data_len           <= 7'd0;
      idle_cnt           <= 4'd0;
      rtr                <= 1'b0;
      prev_bit           <= 1'b1;
      dlc_sh             <= 3'd0;
      rx_dlc             <= 4'd0;
      bit_de_stuffing_en <= 1'b0;
      rx_bit_valid       <= 1'b0;
      rx_bit_data        <= 1'b0;
      frame_done         <= 1'b0;
      err                <= 2'b00;
    end else if (reset_mode) begin
      state              <= WAIT_IDLE;
      bit_cnt            <= 7'd0;
      data_len           <= 7'd0;
      idle_cnt           <= 4'd0;
      rtr                <= 1'b0;
      prev_bit           <= 1'b1;
      dlc_sh             <= 3'd0;
      rx_dlc             <= 4'd0;
      bit_de_stuffing_en <= 1'b0;
      rx_bit_valid       <= 1'b0;
      rx_bit_data        <= 1'b0;
      frame_done         <= 1'b0;
      err                <= 2'b00;
    end else begin
      rx_bit_valid <= 1'b0;
      frame_done   <= 1'b0;
      err          <= 2'b00;
      if (bit_start_point) begin
        prev_bit <= rx_bit;
        if (stuff_region && remove_stuff_bit) begin
          // A legal stuff bit is the complement of the bit before it.
          if (rx_bit == prev_bit) begin
            err                <= 2'b01;
            state              <= WAIT_IDLE;
            bit_cnt            <= 7'd0;
            idle_cnt           <= 4'd0;
            bit_de_stuffing_en <= 1'b0;
          end
        end else begin
          case (state)
            WAIT_IDLE: begin
              if (!rx_bit) begin
                idle_cnt <= 4'd0;
              end else if (idle_cnt == 4'd10) begin
                state    <= IDLE;
                idle_cnt <= 4'd0;
                bit_cnt  <= 7'd0;
              end else begin
                idle_cnt <= idle_cnt + 4'd1;
              end
            end
            IDLE: begin
              if (!rx_bit) begin
                state              <= ARB;
                bit_cnt            <= 7'd0;
                bit_de_stuffing_en <= 1'b1;
              end
            end
            ARB: begin
              rx_bit_valid <= 1'b1;
              rx_bit_data  <= rx_bit;
              bit_cnt      <= bit_cnt + 7'd1;
              if (bit_cnt == 7'd11) begin
                rtr     <= rx_bit;
                state   <= CTRL;
                bit_cnt <= 7'd0;
              end
            end
            CTRL: begin
              rx_bit_valid <= 1'b1;
              rx_bit_data  <= rx_bit;
              bit_cnt      <= bit_cnt + 7'd1;
              if (bit_cnt == 7'd0 && rx_bit) begin
                err                <= 2'b11;
                state              <= WAIT_IDLE;
                bit_cnt            <= 7'd0;
                idle_cnt           <= 4'd0;
                bit_de_stuffing_en <= 1'b0;
              end else if (bit_cnt >= 7'd2 && bit_cnt <= 7'd4) begin
                dlc_sh <= {dlc_sh[1:0], rx_bit};
              end else if (bit_cnt == 7'd5) begin
                rx_dlc  <= dlc_new;
                bit_cnt <= 7'd0;
                // Remote frames and DLC 0 carry no data field.
                if (rtr || len_new == 7'd0) begin
                  state <= CRC;
                end else begin
                  data_len <= len_new;
                  state    <= DATA;
                end
              end
            end
            DATA: begin
              rx_bit_valid <= 1'b1;
              rx_bit_data  <= rx_bit;
              bit_cnt      <= bit_cnt + 7'd1;
              if (bit_cnt == data_len - 7'd1) begin
                state   <= CRC;
                bit_cnt <= 7'd0;
              end
            end
            CRC: begin
              rx_bit_valid <= 1'b1;
              rx_bit_data  <= rx_bit;
              bit_cnt      <= bit_cnt + 7'd1;
              if (bit_cnt == 7'd14) begin
                state              <= TAIL;
                bit_cnt            <= 7'd0;
                bit_de_stuffing_en <= 1'b0;
              end
            end
            TAIL: begin
              bit_cnt <= bit_cnt + 7'd1;
              if ((bit_cnt == 7'd0 || bit_cnt == 7'd2) && !rx_bit) begin
                err      <= 2'b10;
                state    <= WAIT_IDLE;
                bit_cnt  <= 7'd0;
                idle_cnt <= 4'd0;
              end else if (bit_cnt == 7'd2) begin
                state   <= EOF;
                bit_cnt <= 7'd0;
              end
            end
            EOF: begin
              bit_cnt <= bit_cnt + 7'd1;
              if (!rx_bit) begin
                err      <= 2'b10;
                state    <= WAIT_IDLE;
                bit_cnt  <= 7'd0;
                idle_cnt <= 4'd0;
              end else if (bit_cnt == 7'd6) begin
                frame_done <= 1'b1;
                state      <= IDLE;
                bit_cnt    <= 7'd0;
              end
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_can_rx_frame_seq.sv
// Randomised frame bench: builds stuffed CAN frames from field rules and compares the de-stuffed stream and status.
module tb_can_rx_frame_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       reset_mode;
  logic       bit_start_point;
  logic       rx_bit;
  logic       remove_stuff_bit;
  logic       bit_de_stuffing_en;
  logic       rx_bit_valid;
  logic       rx_bit_data;
  logic [2:0] field;
  logic [3:0] rx_dlc;
  logic       frame_done;
  logic [1:0] err;

  can_rx_frame_seq dut (
    .clk                (clk),
    .rst                (rst),
    .reset_mode         (reset_mode),
    .bit_start_point    (bit_start_point),
    .rx_bit             (rx_bit),
    .remove_stuff_bit   (remove_stuff_bit),
    .bit_de_stuffing_en (bit_de_stuffing_en),
    .rx_bit_valid       (rx_bit_valid),
    .rx_bit_data        (rx_bit_data),
    .field              (field),
    .rx_dlc             (rx_dlc),
    .frame_done         (frame_done),
    .err                (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Monitor: accumulates everything the DUT reports; the stimulus only takes snapshots.
  bit         obs_q[$];
  int         fd_cnt = 0;
  int         err_cnt = 0;
  logic [1:0] last_err = 2'b00;

  always @(negedge clk) begin
    if (rx_bit_valid === 1'b1) obs_q.push_back(rx_bit_data);
    if (frame_done === 1'b1) fd_cnt++;
    if (err !== 2'b00) begin
      err_cnt++;
      last_err = err;
    end
  end

  // Current stimulus frame: stuffed wire bits, stuff flags, source raw index, expected destuffed bits.
  bit s_bit[$];
  bit s_stf[$];
  int s_src[$];
  bit exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic send_bit(input bit b, input bit stf);
    @(negedge clk);
    rx_bit           = b;
    remove_stuff_bit = stf;
    bit_start_point  = 1'b1;
    @(negedge clk);
    bit_start_point  = 1'b0;
    remove_stuff_bit = $urandom_range(0, 1);
    rx_bit           = $urandom_range(0, 1);
    @(negedge clk);
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic idle11();
    repeat (11) send_bit(1'b1, 1'b0);
  endtask

  function automatic int data_bits(input bit rtr, input int dlc);
    return rtr ? 0 : 8 * ((dlc > 8) ? 8 : dlc);
  endfunction

  // Raw frame SOF..CRC from field rules, then bit stuffing after every run of five equal bits.
  task automatic build(input bit rtr, input int dlc, input bit zero_data);
    bit raw[$];
    int run;
    bit last;
    raw.push_back(1'b0);
    for (int i = 0; i < 11; i++) raw.push_back(1'($urandom_range(0, 1)));
    raw.push_back(rtr);
    raw.push_back(1'b0);
    raw.push_back(1'b0);
    for (int i = 3; i >= 0; i--) raw.push_back(1'((dlc >> i) & 1));
    for (int i = 0; i < data_bits(rtr, dlc); i++) raw.push_back(zero_data ? 1'b0 : 1'($urandom_range(0, 1)));
    for (int i = 0; i < 15; i++) raw.push_back(1'($urandom_range(0, 1)));
    exp_q = raw[1:$];
    s_bit = {};
    s_stf = {};
    s_src = {};
    run   = 0;
    last  = 1'b0;
    for (int i = 0; i < raw.size(); i++) begin
      s_bit.push_back(raw[i]);
      s_stf.push_back(1'b0);
      s_src.push_back(i);
      if (i == 0 || raw[i] != last) run = 1;
      else run++;
      last = raw[i];
      if (run == 5 && i < raw.size() - 1) begin
        s_bit.push_back(~last);
        s_stf.push_back(1'b1);
        s_src.push_back(i);
        last = ~last;
        run  = 1;
      end
    end
  endtask

  task automatic send_frame(input bit rtr, input int dlc, input string tag);
    int base_v, base_fd, base_err, nmis, nobs;
    base_v   = obs_q.size();
    base_fd  = fd_cnt;
    base_err = err_cnt;
    build(rtr, dlc, 1'b0);
    for (int k = 0; k < s_bit.size(); k++) begin
      send_bit(s_bit[k], s_stf[k]);
      if (k == 0) begin
        chk({tag, "_sof_field"}, field, 2);
        chk({tag, "_sof_destuff_en"}, bit_de_stuffing_en, 1);
      end
    end
    send_bit(1'b1, 1'b0);
    send_bit(1'($urandom_range(0, 1)), 1'b0);
    send_bit(1'b1, 1'b0);
    repeat (7) send_bit(1'b1, 1'b0);
    nobs = obs_q.size() - base_v;
    chk({tag, "_valid_count"}, nobs, 12 + 6 + data_bits(rtr, dlc) + 15);
    nmis = 0;
    for (int i = 0; i < exp_q.size() && i < nobs; i++)
      if (obs_q[base_v + i] != exp_q[i]) nmis++;
    chk({tag, "_bit_mismatches"}, nmis, 0);
    chk({tag, "_rx_dlc"}, rx_dlc, dlc);
    chk({tag, "_frame_done"}, fd_cnt - base_fd, 1);
    chk({tag, "_no_err"}, err_cnt - base_err, 0);
    chk({tag, "_field_idle"}, field, 1);
  endtask

  initial begin
    int base_v, base_fd, base_err, k;
    rst = 1'b1;
    reset_mode = 1'b0;
    bit_start_point = 1'b0;
    rx_bit = 1'b1;
    remove_stuff_bit = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_field", field, 0);
    chk("rst_destuff_en", bit_de_stuffing_en, 0);
    chk("rst_valid", rx_bit_valid, 0);
    chk("rst_dlc", rx_dlc, 0);
    chk("rst_err", err, 0);
    chk("rst_done", frame_done, 0);
    rst = 1'b0;

    repeat (10) send_bit(1'b1, 1'b0);
    chk("idle_after10", field, 0);
    send_bit(1'b0, 1'b0);
    repeat (10) send_bit(1'b1, 1'b0);
    chk("idle_dom_restart", field, 0);
    send_bit(1'b1, 1'b0);
    chk("idle_after11", field, 1);

    send_frame(1'b0, 2, "data_dlc2");
    chk("data_dlc2_49", obs_q.size() >= 49, 1);
    send_frame(1'b1, 15, "remote_dlc15");
    for (int f = 0; f < 6; f++)
      send_frame(1'($urandom_range(0, 1)), $urandom_range(0, 15), "rand");

    // Stuff error inside the data field.
    base_fd  = fd_cnt;
    base_err = err_cnt;
    build(1'b0, 2, 1'b1);
    k = -1;
    for (int i = 0; i < s_bit.size(); i++)
      if (k < 0 && s_stf[i] && s_src[i] >= 19) k = i;
    chk("stuff_found", k >= 0, 1);
    if (k > 0) begin
      for (int i = 0; i < k; i++) send_bit(s_bit[i], s_stf[i]);
      chk("stuff_in_data", field, 4);
      send_bit(s_bit[k - 1], 1'b1);
      chk("stuff_err_code", last_err, 1);
      chk("stuff_err_count", err_cnt - base_err, 1);
      chk("stuff_field", field, 0);
      chk("stuff_destuff_en", bit_de_stuffing_en, 0);
      chk("stuff_no_done", fd_cnt - base_fd, 0);
    end
    idle11();
    chk("stuff_recover", field, 1);

    // Form error on EOF bit 4.
    base_fd  = fd_cnt;
    base_err = err_cnt;
    build(1'b0, $urandom_range(0, 8), 1'b0);
    for (int i = 0; i < s_bit.size(); i++) send_bit(s_bit[i], s_stf[i]);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    repeat (3) send_bit(1'b1, 1'b0);
    chk("eof_field", field, 7);
    send_bit(1'b0, 1'b0);
    chk("eof_err_code", last_err, 2);
    chk("eof_err_count", err_cnt - base_err, 1);
    chk("eof_field_wait", field, 0);
    chk("eof_no_done", fd_cnt - base_fd, 0);
    idle11();

    // Extended (IDE recessive) frame; alternating ID avoids stuff bits.
    base_err = err_cnt;
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 11; i++) send_bit(1'(i % 2), 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    chk("ide_err_code", last_err, 3);
    chk("ide_err_count", err_cnt - base_err, 1);
    chk("ide_field", field, 0);
    idle11();

    // Asynchronous reset in the middle of the data field.
    base_fd  = fd_cnt;
    base_err = err_cnt;
    base_v   = obs_q.size();
    build(1'b0, 8, 1'b0);
    for (int i = 0; i < s_bit.size() && s_src[i] < 25; i++) send_bit(s_bit[i], s_stf[i]);
    chk("rst_mid_in_data", field, 4);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_mid_field", field, 0);
    chk("rst_mid_destuff_en", bit_de_stuffing_en, 0);
    chk("rst_mid_dlc", rx_dlc, 0);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_no_err", err_cnt - base_err, 0);
    chk("rst_mid_no_done", fd_cnt - base_fd, 0);
    send_bit(1'b0, 1'b0);
    chk("rst_mid_no_sof", field, 0);
    repeat (10) send_bit(1'b1, 1'b0);
    chk("rst_mid_after10", field, 0);
    send_bit(1'b1, 1'b0);
    chk("rst_mid_after11", field, 1);

    // Soft reset wins over a SOF in the same sample.
    @(negedge clk);
    reset_mode = 1'b1;
    bit_start_point = 1'b1;
    rx_bit = 1'b0;
    @(negedge clk);
    reset_mode = 1'b0;
    bit_start_point = 1'b0;
    @(negedge clk);
    chk("soft_rst_field", field, 0);
    chk("soft_rst_destuff_en", bit_de_stuffing_en, 0);
    idle11();
    send_frame(1'b0, $urandom_range(1, 8), "after_soft_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
